// File: rtl/aes_pkg.sv
// Shared AES definitions: field polynomial, datapath widths, InvMixColumns FSM
// encoding and the GF(2^8) xtime helper.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         STATE_W  = 128;
  localparam int         COL_W    = STATE_W / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imc_state_e;

  // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column (a0 in the top byte),
// built from an xtime chain so no lookup tables are needed.
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  output logic [COL_W-1:0] o_col
);

  logic [7:0] w_a   [4];
  logic [7:0] w_x2  [4];
  logic [7:0] w_x4  [4];
  logic [7:0] w_x8  [4];
  logic [7:0] w_m09 [4];
  logic [7:0] w_m0b [4];
  logic [7:0] w_m0d [4];
  logic [7:0] w_m0e [4];

  for (genvar i = 0; i < 4; i++) begin : g_row
    assign w_a[i]   = i_col[COL_W-1-8*i -: 8];
    assign w_x2[i]  = xtime(w_a[i]);
    assign w_x4[i]  = xtime(w_x2[i]);
    assign w_x8[i]  = xtime(w_x4[i]);
    assign w_m09[i] = w_x8[i] ^ w_a[i];
    assign w_m0b[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
    assign w_m0d[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
    assign w_m0e[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
    // Row i of the circulant matrix {0e 0b 0d 09} rotated right by i.
    assign o_col[COL_W-1-8*i -: 8] = w_m0e[i] ^ w_m0b[(i+1)%4] ^
                                     w_m0d[(i+2)%4] ^ w_m09[(i+3)%4];
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one column per cycle through a shared column
// unit. Define INV_MIX_COLUMNS_PARALLEL_EN for four units and a 1-cycle BUSY.
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  imc_state_e            r_state;
  imc_state_e            w_next_state;
  logic                  r_in_ready;
  logic                  r_bypass;
  logic [3:0][COL_W-1:0] r_in;   // index 3 holds column 0 (top bits)
  logic [3:0][COL_W-1:0] r_out;
  logic                  w_accept;
  logic                  w_last_col;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
  logic [3:0][COL_W-1:0] w_inv;

  for (genvar g = 0; g < 4; g++) begin : g_col
    inv_mix_single_column u_col (
      .i_col (r_in[g]),
      .o_col (w_inv[g])
    );
  end

  assign w_last_col = 1'b1;
`else
  logic [1:0]       r_col_cnt;
  logic [COL_W-1:0] w_col_in;
  logic [COL_W-1:0] w_col_out;

  // Column c lives at packed index 3-c, i.e. the bitwise inverse of c.
  assign w_col_in   = r_in[~r_col_cnt];
  assign w_last_col = (r_col_cnt == 2'd3);

  inv_mix_single_column u_col (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );
`endif

  assign w_accept  = in_valid && r_in_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == DONE);
  assign out_state = r_out;
  assign busy      = (r_state == BUSY) || (r_state == DONE);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = BUSY;
      BUSY:    if (r_bypass || w_last_col) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == IDLE);
    end
  end

  // NOTE: the data registers are plain flops, so clearing them on reset is cheap and
  // guarantees an aborted operation leaves no stale result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in     <= '0;
      r_out    <= '0;
      r_bypass <= 1'b0;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
      r_col_cnt <= 2'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in     <= in_state;
            r_bypass <= in_bypass;
`ifndef INV_MIX_COLUMNS_PARALLEL_EN
            r_col_cnt <= 2'd0;
`endif
          end
        end
        BUSY: begin
          if (r_bypass) begin
            r_out <= r_in;
          end else begin
`ifdef INV_MIX_COLUMNS_PARALLEL_EN
            r_out <= w_inv;
`else
            r_out[~r_col_cnt] <= w_col_out;
            r_col_cnt         <= r_col_cnt + 2'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed vectors, backpressure,
// bypass, mid-operation reset and a randomized MixColumns round trip.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam int N_RT = 1000;

  localparam logic [127:0] V1_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V1_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V2_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] V2_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] V_BYP  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V_JUNK = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Matrix product of each column with the forward or inverse circulant matrix.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b ^= gmul(coef[(j - i + 4) % 4], a[j]);
        r[127-32*c-8*i -: 8] = b;
      end
    end
    return r;
  endfunction

  // Present one state, wait for acceptance and then for out_valid (bounded).
  task automatic transact(input string tag, input logic [127:0] st, input logic byp,
                          input int exp_lat);
    int lat;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_state  = st;
    in_bypass = byp;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    check({tag, "_busy"}, 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] q[$];
    logic [127:0] orig;
    logic         acc;
    logic         hand;
    int           sent;
    int           got;
    int           cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  128'(in_ready),  128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state,       128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 vector with out_ready held high.
    out_ready = 1'b1;
    transact("fips", V1_IN, 1'b0, LAT);
    check("fips_out_state", out_state, V1_OUT);
    tick();
    check("fips_handoff_valid", 128'(out_valid), 128'(0));
    check("fips_handoff_ready", 128'(in_ready),  128'(1));

    // Column vectors.
    transact("cols", V2_IN, 1'b0, LAT);
    check("cols_out_state", out_state, V2_OUT);
    tick();

    // Backpressure with a competing input that must be ignored.
    out_ready = 1'b0;
    transact("bp", V1_IN, 1'b0, LAT);
    for (int i = 0; i < 10; i++) begin
      in_state = V_JUNK;
      in_valid = 1'b1;
      tick();
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_state", out_state,       V1_OUT);
      check("bp_in_ready",  128'(in_ready),  128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_busy",  128'(busy),      128'(0));

    // Bypass passes the state unchanged after one cycle.
    transact("byp", V_BYP, 1'b1, 1);
    check("byp_out_state", out_state, V_BYP);
    tick();

    // Reset two cycles into BUSY (col_cnt==2 in the sequential build).
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    in_state = V1_IN;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_out_state", out_state,       128'(0));
    check("midrst_busy",      128'(busy),      128'(0));
    check("midrst_in_ready",  128'(in_ready),  128'(0));
    @(negedge clk) rst_n = 1'b1;
    transact("fips2", V1_IN, 1'b0, LAT);
    check("fips2_out_state", out_state, V1_OUT);
    tick();

    // Round trip: MixColumns model feeds the DUT, random backpressure.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < N_RT && cyc < 40000) begin
      if (!in_valid && sent < N_RT && $urandom_range(0, 3) != 0) begin
        orig     = {$urandom, $urandom, $urandom, $urandom};
        in_state = mix_model(orig, 1'b0);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      acc  = in_valid && in_ready;
      hand = out_valid && out_ready;
      if (acc) q.push_back(orig);
      if (hand) begin
        if (q.size() == 0) check("rt_extra_output", out_state, 128'(0) - 128'(1) ^ out_state);
        else check("rt_data", out_state, q.pop_front());
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("rt_count",   128'(got),      128'(N_RT));
    check("rt_pending", 128'(q.size()), 128'(0));

    // Model self-consistency on a random state (inverse of forward).
    orig = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    transact("rt_final", mix_model(orig, 1'b0), 1'b0, LAT);
    check("rt_final_out", out_state, mix_model(mix_model(orig, 1'b0), 1'b1));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
